// File: rtl/acra_err_corrector.sv
// Checker/corrector for an ACRA approximate adder: recomputes the exact sum,
// reports the error against the approximate result and keeps running statistics.
module acra_err_corrector #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sapp,
   input  logic [WIDTH-1:0] approx_sum,
   input  logic             approx_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   exact_sum,
   output logic             err_flag,
   output logic [WIDTH:0]   err_dist,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH:0]   max_err,
   output logic             hard_fault
);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; a producer holding valid keeps its data stable until accepted.
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   logic             s1_cin_q, s1_sapp_q;
   logic [WIDTH:0]   s1_approx_q;

   logic             s2_valid_q;
   logic [WIDTH:0]   s2_exact_q, s2_dist_q;
   logic             s2_flag_q, s2_sapp_q;

   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH:0]   max_err_q, max_err_d;
   logic             hard_fault_q, hard_fault_d;

   logic             advance, in_fire, out_fire;
   logic [WIDTH:0]   s1_exact, s1_dist;

   assign advance  = !s2_valid_q || out_ready;
   assign in_ready = advance || !s1_valid_q;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;

   assign s1_exact = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};
   assign s1_dist  = (s1_exact >= s1_approx_q) ? (s1_exact - s1_approx_q)
                                               : (s1_approx_q - s1_exact);

   // clear takes priority over a same-cycle result handshake.
   always_comb begin
      sample_cnt_d = sample_cnt_q;
      err_cnt_d    = err_cnt_q;
      max_err_d    = max_err_q;
      hard_fault_d = hard_fault_q;
      if (out_fire && s2_flag_q && !s2_sapp_q)
         hard_fault_d = 1'b1;
      if (clear) begin
         sample_cnt_d = '0;
         err_cnt_d    = '0;
         max_err_d    = '0;
      end else if (out_fire) begin
         if (sample_cnt_q != '1)
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
         if (s2_flag_q && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + CNT_W'(1);
         if (s2_dist_q > max_err_q)
            max_err_d = s2_dist_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_cin_q     <= 1'b0;
         s1_sapp_q    <= 1'b0;
         s1_approx_q  <= '0;
         s2_valid_q   <= 1'b0;
         s2_exact_q   <= '0;
         s2_dist_q    <= '0;
         s2_flag_q    <= 1'b0;
         s2_sapp_q    <= 1'b0;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         max_err_q    <= '0;
         hard_fault_q <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid_q  <= 1'b1;
            s1_a_q      <= a;
            s1_b_q      <= b;
            s1_cin_q    <= cin;
            s1_sapp_q   <= sapp;
            s1_approx_q <= {approx_cout, approx_sum};
         end else if (advance) begin
            s1_valid_q  <= 1'b0;
         end
         if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_exact_q <= s1_exact;
            s2_dist_q  <= s1_dist;
            s2_flag_q  <= (s1_dist != '0);
            s2_sapp_q  <= s1_sapp_q;
         end
         sample_cnt_q <= sample_cnt_d;
         err_cnt_q    <= err_cnt_d;
         max_err_q    <= max_err_d;
         hard_fault_q <= hard_fault_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign exact_sum  = s2_exact_q;
   assign err_flag   = s2_flag_q;
   assign err_dist   = s2_dist_q;
   assign sample_cnt = sample_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign max_err    = max_err_q;
   assign hard_fault = hard_fault_q;

endmodule

// File: tb/tb_acra_err_corrector.sv
// Directed bench for acra_err_corrector: hand-checked vectors, a stall/ordering
// scenario with an expected queue, counter saturation, clear and reset behaviour.
module tb_acra_err_corrector;
   localparam int WIDTH = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst, clear, in_valid, in_ready;
   logic [WIDTH-1:0] a, b, approx_sum;
   logic             cin, sapp, approx_cout;
   logic             out_valid, out_ready;
   logic [WIDTH:0]   exact_sum, err_dist, max_err;
   logic             err_flag, hard_fault;
   logic [CNT_W-1:0] sample_cnt, err_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int idx, got;

   logic [2*WIDTH+1:0] exp_q[$];
   logic [WIDTH-1:0]   va[4], vb[4], vapp[4];
   logic               vcin[4], vcout[4];

   acra_err_corrector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sapp(sapp),
      .approx_sum(approx_sum), .approx_cout(approx_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .exact_sum(exact_sum), .err_flag(err_flag), .err_dist(err_dist),
      .sample_cnt(sample_cnt), .err_cnt(err_cnt), .max_err(max_err),
      .hard_fault(hard_fault)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {dist, exact} for one sample.
   function automatic logic [2*WIDTH+1:0] model(input logic [WIDTH-1:0] ma, mb,
                                                input logic mcin,
                                                input logic mcout,
                                                input logic [WIDTH-1:0] msum);
      logic [WIDTH:0] ex, ap, d;
      ex = WIDTH'(0) + ma;
      ex = ex + mb + mcin;
      ap = {mcout, msum};
      d  = (ex >= ap) ? ex - ap : ap - ex;
      return {d, ex};
   endfunction

   task automatic drive(input logic [WIDTH-1:0] ta, tb, input logic tcin, tsapp,
                        input logic tcout, input logic [WIDTH-1:0] tsum);
      a = ta; b = tb; cin = tcin; sapp = tsapp;
      approx_cout = tcout; approx_sum = tsum;
      in_valid = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [WIDTH-1:0] ta, tb, input logic tcin, tsapp,
                       input logic tcout, input logic [WIDTH-1:0] tsum);
      logic ok;
      ok = 1'b0;
      drive(ta, tb, tcin, tsapp, tcout, tsum);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         tick();
      end
      if (!ok) check_eq("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sapp = 1'b0; approx_sum = '0; approx_cout = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_sample_cnt", sample_cnt, 0);
      check_eq("rst_hard_fault", hard_fault, 0);

      // Vector 1: single-LSB error in approx mode.
      out_ready = 1'b1;
      send(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F);
      check_eq("v1_early_valid", out_valid, 0);
      tick();
      check_eq("v1_valid", out_valid, 1);
      check_eq("v1_exact", exact_sum, 9'h010);
      check_eq("v1_flag", err_flag, 1);
      check_eq("v1_dist", err_dist, 9'h001);
      tick();
      check_eq("v1_sample_cnt", sample_cnt, 1);
      check_eq("v1_err_cnt", err_cnt, 1);
      check_eq("v1_max_err", max_err, 1);

      // Vector 2: exact result in exact mode.
      send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF);
      tick();
      check_eq("v2_exact", exact_sum, 9'h1FF);
      check_eq("v2_flag", err_flag, 0);
      check_eq("v2_dist", err_dist, 0);
      tick();
      check_eq("v2_hard_fault", hard_fault, 0);
      check_eq("v2_sample_cnt", sample_cnt, 2);
      check_eq("v2_err_cnt", err_cnt, 1);

      // Vector 3: error while exact mode -> hard fault, survives clear.
      send(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      check_eq("v3_exact", exact_sum, 9'h100);
      check_eq("v3_dist", err_dist, 9'h100);
      check_eq("v3_flag", err_flag, 1);
      tick();
      check_eq("v3_hard_fault", hard_fault, 1);
      check_eq("v3_max_err", max_err, 9'h100);
      check_eq("v3_err_cnt", err_cnt, 2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_eq("v3_clr_sample_cnt", sample_cnt, 0);
      check_eq("v3_clr_err_cnt", err_cnt, 0);
      check_eq("v3_clr_max_err", max_err, 0);
      check_eq("v3_clr_hard_fault", hard_fault, 1);

      // Stall: four samples against a blocked output.
      va[0] = 8'h10; vb[0] = 8'h20; vcin[0] = 1'b0; vcout[0] = 1'b0; vapp[0] = 8'h30;
      va[1] = 8'h01; vb[1] = 8'h01; vcin[1] = 1'b1; vcout[1] = 1'b0; vapp[1] = 8'h00;
      va[2] = 8'hF0; vb[2] = 8'h20; vcin[2] = 1'b0; vcout[2] = 1'b0; vapp[2] = 8'h00;
      va[3] = 8'h05; vb[3] = 8'h03; vcin[3] = 1'b0; vcout[3] = 1'b0; vapp[3] = 8'h0A;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         drive(va[idx], vb[idx], vcin[idx], 1'b1, vcout[idx], vapp[idx]);
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(va[idx], vb[idx], vcin[idx], vcout[idx], vapp[idx]));
            idx++;
         end
         tick();
      end
      check_eq("stall_accepted", idx, 2);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_exact", exact_sum, 9'h030);
      tick(); tick(); tick();
      check_eq("stall_hold_exact", exact_sum, 9'h030);
      check_eq("stall_hold_valid", out_valid, 1);

      out_ready = 1'b1;
      got = 0;
      fork
         begin
            for (int c = 0; c < 30 && idx < 4; c++) begin
               drive(va[idx], vb[idx], vcin[idx], 1'b1, vcout[idx], vapp[idx]);
               @(negedge clk);
               if (in_ready) begin
                  exp_q.push_back(model(va[idx], vb[idx], vcin[idx], vcout[idx], vapp[idx]));
                  idx++;
               end
               tick();
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 30 && got < 4; c++) begin
               @(negedge clk);
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) check_eq("stream_extra", 1, 0);
                  else check_eq("stream_result", {err_dist, exact_sum}, exp_q.pop_front());
                  got++;
               end
            end
         end
      join
      tick();
      check_eq("stream_count", got, 4);
      check_eq("stream_left", exp_q.size(), 0);
      check_eq("stream_sample_cnt", sample_cnt, 4);
      check_eq("stream_err_cnt", err_cnt, 3);
      check_eq("stream_max_err", max_err, 9'h110);

      // clear beats a same-cycle erroring handshake.
      send(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_eq("clr_hs_sample_cnt", sample_cnt, 0);
      check_eq("clr_hs_err_cnt", err_cnt, 0);
      check_eq("clr_hs_max_err", max_err, 0);
      check_eq("clr_hs_out_valid", out_valid, 0);

      // Saturation: 0xFFFE samples streamed, then three more.
      idx = 0;
      drive(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 70000 && idx < 65534; c++) begin
         @(negedge clk);
         if (in_ready) idx++;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      check_eq("sat_pre_sample_cnt", sample_cnt, 16'hFFFE);
      check_eq("sat_pre_err_cnt", err_cnt, 16'hFFFE);
      for (int k = 0; k < 3; k++) send(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      tick(); tick(); tick(); tick();
      check_eq("sat_sample_cnt", sample_cnt, 16'hFFFF);
      check_eq("sat_err_cnt", err_cnt, 16'hFFFF);
      check_eq("sat_max_err", max_err, 1);

      // Reset with both stages full.
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00);
      send(8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("full_out_valid", out_valid, 1);
      check_eq("full_in_ready", in_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_sample_cnt", sample_cnt, 0);
      check_eq("mid_rst_err_cnt", err_cnt, 0);
      check_eq("mid_rst_max_err", max_err, 0);
      check_eq("mid_rst_hard_fault", hard_fault, 0);
      check_eq("mid_rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick(); tick(); tick();
      check_eq("mid_rst_drained", out_valid, 0);
      check_eq("mid_rst_no_count", sample_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
